// File: rtl/johnson_ring_counter_param.sv
// Parametrised Johnson / one-hot ring sequence counter with up/down count,
// parallel load by step index, wrap pulse, encoded step index and
// self-correction of illegal register states.
module johnson_ring_counter_param #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IW    = $clog2(2*WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [IW-1:0]    load_idx_i,
  output logic [WIDTH-1:0] data_o,
  output logic [IW-1:0]    idx_o,
  output logic             wrap_o,
  output logic             err_o
);

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  mode_e            mode_q, mode_d, mode_in;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             legal;
  int unsigned      period_cur;
  int unsigned      cur_idx;
  int unsigned      load_idx;

  // Register image for step k of the selected mode.
  function automatic logic [WIDTH-1:0] step_enc(input mode_e m, input int unsigned k);
    logic [WIDTH-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (m == MODE_RING)  e[i] = (i == k);
      else if (k <= WIDTH) e[i] = (i < k);
      else                 e[i] = (i >= k - WIDTH);
    end
    return e;
  endfunction

  function automatic int unsigned period(input mode_e m);
    return (m == MODE_RING) ? WIDTH : 2 * WIDTH;
  endfunction

  assign mode_in  = mode_e'(mode_i);
  assign cur_idx  = 32'(idx_q);
  assign load_idx = 32'(load_idx_i);

  // Legality of the present register value within the current mode's sequence.
  always_comb begin
    period_cur = period(mode_q);
    legal      = 1'b0;
    for (int unsigned k = 0; k < 2 * WIDTH; k++) begin
      if (k < period_cur && data_q == step_enc(mode_q, k)) legal = 1'b1;
    end
  end

  // Next-state selection: mode change > illegal state > load > count > hold.
  always_comb begin
    mode_d = mode_q;
    data_d = data_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (mode_in != mode_q) begin
      mode_d = mode_in;
      data_d = step_enc(mode_in, 0);
      idx_d  = '0;
    end else if (!legal) begin
      data_d = step_enc(mode_q, 0);
      idx_d  = '0;
      err_d  = 1'b1;
    end else if (load_i) begin
      if (load_idx < period_cur) begin
        data_d = step_enc(mode_q, load_idx);
        idx_d  = load_idx_i;
      end else begin
        data_d = step_enc(mode_q, 0);
        idx_d  = '0;
        err_d  = 1'b1;
      end
    end else if (en_i) begin
      if (!dir_i) begin
        data_d = (mode_q == MODE_RING) ? {data_q[WIDTH-2:0], data_q[WIDTH-1]}
                                       : {data_q[WIDTH-2:0], ~data_q[WIDTH-1]};
        if (cur_idx == period_cur - 1) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = IW'(cur_idx + 1);
        end
      end else begin
        data_d = (mode_q == MODE_RING) ? {data_q[0], data_q[WIDTH-1:1]}
                                       : {~data_q[0], data_q[WIDTH-1:1]};
        if (cur_idx == 0) begin
          idx_d  = IW'(period_cur - 1);
          wrap_d = 1'b1;
        end else begin
          idx_d = IW'(cur_idx - 1);
        end
      end
    end
  end

  // State and pulse registers with synchronous reset to the start of mode_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= mode_in;
      data_q <= step_enc(mode_in, 0);
      idx_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      data_q <= data_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign data_o = data_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule

// File: doc/johnson_ring_counter_param.md
Name: johnson_ring_counter_param

Overview:
Parametrised shift-register sequence counter that generalises the fixed 8-bit Johnson counter. It has a runtime-selectable Johnson (twisted-ring) or one-hot ring mode, and adds up/down direction, enable, parallel load by step index, a wrap pulse and an encoded step index. Any illegal register state is detected and self-corrected. It is used as a glitch-free phase/sequence generator in the Counters library.

Parameters:
WIDTH, 8, register width in bits (legal: WIDTH >= 2)
IW, $clog2(2*WIDTH), width of the step index; derived localparam, not overridable

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
en_i  input  1  advance one step per cycle when high
dir_i  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB)
mode_i  input  1  0 = Johnson (period 2*WIDTH), 1 = ring (period WIDTH)
load_i  input  1  load the state for step load_idx_i
load_idx_i  input  IW  target step index for load
data_o  output  WIDTH  counter register
idx_o  output  IW  step index of data_o
wrap_o  output  1  one-cycle pulse on sequence wrap
err_o  output  1  one-cycle pulse on illegal state or illegal load index

Behaviour:
- Reset: all outputs are registered; everything updates only on posedge clk_i.
  - rst_i=1 gives data_o = start state of current mode_i (Johnson 0, ring 1), idx_o=0, wrap_o=0, err_o=0, mode_q=mode_i.
- Step encoding, Johnson mode, P = 2*WIDTH:
  - k in 0..WIDTH: low k bits are 1.
  - k in WIDTH+1..2W-1: top 2W-k bits are 1.
  - WIDTH=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Step encoding, ring mode, P = WIDTH: step k gives data_o = 1<<k.
- Next-state function:
  - Johnson up: {d[W-2:0], ~d[W-1]}. Johnson down: {~d[0], d[W-1:1]}.
  - Ring up: {d[W-2:0], d[W-1]}. Ring down: {d[0], d[W-1:1]}.
  - idx_o tracks data_o in the same cycle: up gives (idx+1) mod P, down gives (idx-1) mod P.
- Priority, highest first, evaluated each cycle: rst_i > mode change > illegal state > load_i > en_i > hold.
- Mode change: mode_q is the registered mode_i.
  - If mode_i != mode_q, load the start state of the new mode, set idx_o=0, update mode_q.
  - No wrap_o, no err_o; load_i and en_i are ignored that cycle.
- Illegal state: data_o not in the current mode's sequence (e.g. Johnson 0101, ring 0000 or 0110).
  - Load the start state, set idx_o=0, pulse err_o for one cycle; load_i and en_i are ignored.
  - Checked combinationally on the present register value.
- Load:
  - load_idx_i < P: load the step encoding of load_idx_i, set idx_o=load_idx_i.
  - load_idx_i >= P: load the start state, set idx_o=0, pulse err_o.
  - Load never pulses wrap_o.
- Count: with en_i=1 and nothing higher-priority active, advance one step.
  - wrap_o=1 in the cycle data_o becomes step 0 from step P-1 (up), or step P-1 from step 0 (down).
- Hold: en_i=0 keeps data_o and idx_o; wrap_o=0, err_o=0.
- Pulse outputs: wrap_o and err_o are never high together. Both deassert the cycle after they fire unless the event repeats.
- Direction may change on any cycle. The next step uses the new direction, with no extra latency.
- Reset mid-sequence or mid-load: reset wins and the start state appears on the next edge.

Test Plan:
- WIDTH=4, mode 0, rst then en_i=1 up for 9 cycles -> data_o 0000,0001,0011,0111,1111,1110,1100,1000,0000; idx_o 0..7,0; wrap_o high only on the return to 0000.
- WIDTH=4, mode 0, from idx 2 (0011), dir_i=1 for 3 cycles -> 0001, 0000, 1000 (idx 7) with wrap_o on the 1000 cycle; toggle dir_i back -> 0000.
- WIDTH=4, mode 1, up 5 cycles -> 0001,0010,0100,1000,0001 with wrap_o on the last. Then switch mode_i=0 while en_i=1 -> next data_o=0000, idx_o=0, no wrap_o/err_o.
- WIDTH=4, mode 0, load_i with load_idx_i=6 -> data_o=1100, idx_o=6. Load with idx 7 in mode 1 -> data_o=0001, idx_o=0, err_o pulse.
- Force data_o register to 0101 (mode 0) with en_i=1 -> next cycle 0000, idx_o=0, err_o=1 for exactly one cycle, then normal counting resumes.
- Assert rst_i concurrently with load_i and a mode change -> start state of the new mode_i, idx_o=0, no pulses. Then en_i=0 for 3 cycles -> outputs hold.
